// File: rtl/cpu_pkg.sv
// Shared definitions for the mini CPU: data widths, opcode encodings and
// the execution-unit state encoding, plus overflow helpers.
package cpu_pkg;

    localparam int CPU_WIDTH = 16;
    localparam int CPU_IMM_W = 7;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_SUBI = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_SLL  = 3'b111;

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        CALC   = 3'd1,
        MULT   = 3'd2,
        PRONTO = 3'd3,
        LIBERA = 3'd4
    } estado_t;

    // Signed overflow from the sign bits of the operands and of the result.
    function automatic logic ovf_soma(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic ovf_sub(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/unidade_execucao_if.sv
// Request/acknowledge bus between the register-file controller (master)
// and the execution unit (slave).
interface unidade_execucao_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH,
    parameter int IMM_W = CPU_IMM_W
) ();

    logic             inicio;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] r2;
    logic [WIDTH-1:0] r3;
    logic [IMM_W-1:0] entrada;
    logic             flag_ram;
    logic [WIDTH-1:0] saida;
    logic             fimop;
    logic             estouro;
    logic             ocupado;

    modport master (
        output inicio, opcode, r2, r3, entrada, flag_ram,
        input  saida, fimop, estouro, ocupado
    );

    modport slave (
        input  inicio, opcode, r2, r3, entrada, flag_ram,
        output saida, fimop, estouro, ocupado
    );

endinterface

// File: rtl/unidade_execucao_multiplicador_serial.sv
// Unsigned serial shift-add multiplier: one partial-product step per cycle,
// W steps, then a single-cycle done pulse with the full 2W-bit product.
module multiplicador_serial #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_start,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic           o_done,
    output logic [2*W-1:0] o_produto
);

    localparam int            CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_UM   = CW'(1);
    localparam logic [CW-1:0] CNT_ULT  = CW'(W - 1);

    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic [2*W-1:0] r_prod;
    logic [CW-1:0]  r_cnt;
    logic           r_ativo;
    logic           r_done;

    // Operand capture on start, then one shift-add step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_ativo  <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= {{W{1'b0}}, i_a};
            r_mplier <= i_b;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_ativo  <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_ativo) begin
            if (r_mplier[0]) begin
                r_prod <= r_prod + r_mcand;
            end else begin
                r_prod <= r_prod;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_UM;
            if (r_cnt == CNT_ULT) begin
                r_ativo <= 1'b0;
                r_done  <= 1'b1;
            end else begin
                r_ativo <= 1'b1;
                r_done  <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_done    = r_done;
    assign o_produto = r_prod;

endmodule

// File: rtl/unidade_execucao.sv
// Execution unit: latches operands on request, runs the single-cycle ALU or
// the serial multiplier, and hands the result back over a 4-phase handshake.
module unidade_execucao
    import cpu_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH,
    parameter int IMM_W = CPU_IMM_W
) (
    input  logic                clk,
    input  logic                rst_n,
    unidade_execucao_if.slave   bus
);

    localparam int MSB = WIDTH - 1;

    estado_t          r_estado;
    estado_t          w_prox;
    logic             w_aceita;
    logic             w_carga_alu;
    logic             w_carga_mul;

    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IMM_W-1:0] r_imm;

    logic [WIDTH-1:0] r_saida;
    logic             r_fimop;
    logic             r_estouro;
    logic             r_ocupado;

    logic [WIDTH-1:0] w_imm_ext;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    logic             w_mul_start;
    logic             w_mul_done;
    logic [2*WIDTH-1:0] w_produto;

    assign w_mul_start = w_aceita && (bus.opcode == OP_MUL);

    multiplicador_serial #(.W(WIDTH)) u_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_a       (bus.r2),
        .i_b       (bus.r3),
        .o_done    (w_mul_done),
        .o_produto (w_produto)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox;
        end
    end

    // Next-state and datapath-load decisions.
    always_comb begin
        w_prox      = r_estado;
        w_aceita    = 1'b0;
        w_carga_alu = 1'b0;
        w_carga_mul = 1'b0;
        case (r_estado)
            OCIOSO: begin
                // A stale acknowledge still high blocks a new request.
                if (bus.inicio && !bus.flag_ram) begin
                    w_aceita = 1'b1;
                    w_prox   = (bus.opcode == OP_MUL) ? MULT : CALC;
                end else begin
                    w_prox = OCIOSO;
                end
            end
            CALC: begin
                w_carga_alu = 1'b1;
                w_prox      = PRONTO;
            end
            MULT: begin
                if (w_mul_done) begin
                    w_carga_mul = 1'b1;
                    w_prox      = PRONTO;
                end else begin
                    w_prox = MULT;
                end
            end
            PRONTO: begin
                if (bus.flag_ram) begin
                    w_prox = LIBERA;
                end else begin
                    w_prox = PRONTO;
                end
            end
            LIBERA: begin
                if (!bus.flag_ram && !bus.inicio) begin
                    w_prox = OCIOSO;
                end else begin
                    w_prox = LIBERA;
                end
            end
            default: begin
                w_prox = OCIOSO;
            end
        endcase
    end

    // Single-cycle ALU on the latched operands.
    always_comb begin
        w_imm_ext = {{(WIDTH-IMM_W){r_imm[IMM_W-1]}}, r_imm};
        w_res     = '0;
        w_ovf     = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res = r_a + r_b;
                w_ovf = ovf_soma(r_a[MSB], r_b[MSB], w_res[MSB]);
            end
            OP_ADDI: begin
                w_res = r_a + w_imm_ext;
                w_ovf = ovf_soma(r_a[MSB], w_imm_ext[MSB], w_res[MSB]);
            end
            OP_SUB: begin
                w_res = r_a - r_b;
                w_ovf = ovf_sub(r_a[MSB], r_b[MSB], w_res[MSB]);
            end
            OP_SUBI: begin
                w_res = r_a - w_imm_ext;
                w_ovf = ovf_sub(r_a[MSB], w_imm_ext[MSB], w_res[MSB]);
            end
            OP_AND: begin
                w_res = r_a & r_b;
                w_ovf = 1'b0;
            end
            OP_SLL: begin
                w_res = r_a << r_imm[3:0];
                w_ovf = 1'b0;
            end
            default: begin
                // CLR, and MUL which is served by the serial multiplier.
                w_res = '0;
                w_ovf = 1'b0;
            end
        endcase
    end

    // Operand latches and registered result/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= 3'b000;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_saida   <= '0;
            r_estouro <= 1'b0;
            r_fimop   <= 1'b0;
            r_ocupado <= 1'b0;
        end else begin
            r_fimop   <= (w_prox == PRONTO);
            r_ocupado <= (w_prox != OCIOSO);
            if (w_aceita) begin
                r_op  <= bus.opcode;
                r_a   <= bus.r2;
                r_b   <= bus.r3;
                r_imm <= bus.entrada;
            end else begin
                r_op  <= r_op;
                r_a   <= r_a;
                r_b   <= r_b;
                r_imm <= r_imm;
            end
            // saida keeps the last result until the next one loads.
            if (w_carga_alu) begin
                r_saida   <= w_res;
                r_estouro <= w_ovf;
            end else if (w_carga_mul) begin
                r_saida   <= w_produto[WIDTH-1:0];
                r_estouro <= |w_produto[2*WIDTH-1:WIDTH];
            end else begin
                r_saida   <= r_saida;
                r_estouro <= r_estouro;
            end
        end
    end

    assign bus.saida   = r_saida;
    assign bus.fimop   = r_fimop;
    assign bus.estouro = r_estouro;
    assign bus.ocupado = r_ocupado;

endmodule

// File: tb/tb_unidade_execucao.sv
// Directed self-checking bench for unidade_execucao with a result scoreboard.
module tb_unidade_execucao;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    unidade_execucao_if #(.WIDTH(16), .IMM_W(7)) bus ();

    unidade_execucao #(.WIDTH(16), .IMM_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [15:0] saida;
        logic        estouro;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model written in plain integer arithmetic.
    function automatic exp_t modelo(input logic [2:0] op, input logic [15:0] a,
                                    input logic [15:0] b, input logic [6:0] imm);
        exp_t   e;
        int     sa, sb_i, si, r;
        longint p;
        sa   = $signed(a);
        sb_i = $signed(b);
        si   = $signed(imm);
        e    = '0;
        case (op)
            OP_ADD:  begin r = sa + sb_i; e.saida = r[15:0]; e.estouro = (r > 32767) || (r < -32768); end
            OP_ADDI: begin r = sa + si;   e.saida = r[15:0]; e.estouro = (r > 32767) || (r < -32768); end
            OP_SUB:  begin r = sa - sb_i; e.saida = r[15:0]; e.estouro = (r > 32767) || (r < -32768); end
            OP_SUBI: begin r = sa - si;   e.saida = r[15:0]; e.estouro = (r > 32767) || (r < -32768); end
            OP_MUL:  begin p = longint'(a) * longint'(b); e.saida = p[15:0]; e.estouro = (p > 64'sd65535); end
            OP_AND:  begin e.saida = a & b; e.estouro = 1'b0; end
            OP_CLR:  begin e.saida = 16'h0000; e.estouro = 1'b0; end
            OP_SLL:  begin p = longint'(a) << imm[3:0]; e.saida = p[15:0]; e.estouro = 1'b0; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic drive_op(input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [6:0] imm);
        bus.opcode  = op;
        bus.r2      = a;
        bus.r3      = b;
        bus.entrada = imm;
        bus.inicio  = 1'b1;
        sb.push_back(modelo(op, a, b, imm));
    endtask

    // Waits for fimop, checks latency and result, holds for ack_delay, then acknowledges.
    task automatic complete(input string tag, input int exp_lat, input int ack_delay);
        int          cyc;
        exp_t        e;
        logic [15:0] held;
        @(negedge clk);
        chk({tag, "_ocupado"}, bus.ocupado, 1);
        cyc = 1;
        while (!bus.fimop && cyc < 40) begin
            bus.r2      = 16'($urandom);
            bus.r3      = 16'($urandom);
            bus.entrada = 7'($urandom);
            bus.opcode  = 3'($urandom);
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, cyc - 1, exp_lat);
        chk({tag, "_sb"}, sb.size(), 1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk({tag, "_saida"}, bus.saida, e.saida);
        chk({tag, "_estouro"}, bus.estouro, e.estouro);
        held = bus.saida;
        for (int i = 0; i < ack_delay; i++) begin
            bus.r2      = 16'($urandom);
            bus.r3      = 16'($urandom);
            bus.opcode  = 3'($urandom);
            bus.inicio  = i[0];
            @(negedge clk);
            chk({tag, "_hold_fimop"}, bus.fimop, 1);
            chk({tag, "_hold_saida"}, bus.saida, held);
        end
        bus.flag_ram = 1'b1;
        bus.inicio   = 1'b0;
        @(negedge clk);
        chk({tag, "_fimop_clr"}, bus.fimop, 0);
        chk({tag, "_libera_ocup"}, bus.ocupado, 1);
        bus.flag_ram = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, bus.ocupado, 0);
        chk({tag, "_keep_saida"}, bus.saida, held);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.inicio   = 1'b0;
        bus.opcode   = 3'b000;
        bus.r2       = 16'h0000;
        bus.r3       = 16'h0000;
        bus.entrada  = 7'h00;
        bus.flag_ram = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_saida", bus.saida, 0);
        chk("rst_fimop", bus.fimop, 0);
        chk("rst_estouro", bus.estouro, 0);
        chk("rst_ocupado", bus.ocupado, 0);
        rst_n = 1'b1;
        @(negedge clk);

        drive_op(OP_ADDI, 16'h0005, 16'h0000, 7'h7E); complete("addi", 1, 0);
        drive_op(OP_ADD,  16'h7FFF, 16'h0001, 7'h00); complete("add_ovf", 1, 0);
        drive_op(OP_SUB,  16'h0000, 16'h0001, 7'h00); complete("sub", 1, 0);
        drive_op(OP_MUL,  16'h0123, 16'h0010, 7'h00); complete("mul", 17, 0);
        drive_op(OP_MUL,  16'h0100, 16'h0100, 7'h00); complete("mul_ovf", 17, 0);
        drive_op(OP_AND,  16'hA5A5, 16'h0FF0, 7'h00); complete("and_delay", 1, 10);
        drive_op(OP_CLR,  16'h1234, 16'h5678, 7'h00); complete("clr", 1, 0);
        drive_op(OP_SUB,  16'h8000, 16'h0001, 7'h00); complete("sub_ovf", 1, 0);
        drive_op(OP_SUBI, 16'h0010, 16'h0000, 7'h3F); complete("subi", 1, 0);
        drive_op(OP_MUL,  16'hFFFF, 16'hFFFF, 7'h00); complete("mul_max", 17, 3);

        // Asynchronous reset in the middle of a multiplication.
        drive_op(OP_MUL, 16'h1234, 16'h5678, 7'h00);
        @(negedge clk);
        repeat (8) @(negedge clk);
        chk("mid_mul_ocupado", bus.ocupado, 1);
        chk("mid_mul_fimop", bus.fimop, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_saida", bus.saida, 0);
        chk("arst_fimop", bus.fimop, 0);
        chk("arst_estouro", bus.estouro, 0);
        chk("arst_ocupado", bus.ocupado, 0);
        sb.delete();
        bus.inicio = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_fimop", bus.fimop, 0);
        chk("post_rst_ocupado", bus.ocupado, 0);

        drive_op(OP_SLL, 16'h0001, 16'h0000, 7'h0F); complete("sll", 1, 0);

        // Stale acknowledge blocks acceptance.
        bus.flag_ram = 1'b1;
        drive_op(OP_ADD, 16'h0001, 16'h0002, 7'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale_ocupado", bus.ocupado, 0);
            chk("stale_fimop", bus.fimop, 0);
        end
        bus.flag_ram = 1'b0;
        complete("stale_release", 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidade_execucao.md
# unidade_execucao

Execution unit for the mini CPU: takes the two register-file operands, the 7-bit immediate field and the 3-bit opcode, computes a 16-bit result and returns it to the register-file controller over a four-phase request/acknowledge handshake. Single-cycle ops finish one cycle after acceptance; MUL runs as a 16-step serial shift-add. The controller writes `saida` back to the destination register and acknowledges with `flag_ram`.

## Interface
- `WIDTH`, 16, operand/result width
- `IMM_W`, 7, immediate field width
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `inicio`  in  1  request from the controller; level, held until `fimop` rises
- `opcode`  in  3  operation select
- `r2`  in  WIDTH  operand A (register value)
- `r3`  in  WIDTH  operand B (register value)
- `entrada`  in  IMM_W  immediate; `entrada[3:0]` is also the shift amount
- `flag_ram`  in  1  acknowledge: controller has stored `saida`
- `saida`  out  WIDTH  result, registered
- `fimop`  out  1  result valid; held until acknowledged
- `estouro`  out  1  overflow flag, valid with `fimop`
- `ocupado`  out  1  high in every state except OCIOSO

## Operation
- Opcodes: 000 ADD r2+r3; 001 ADDI r2+sext(entrada); 010 SUB r2−r3; 011 SUBI r2−sext(entrada); 100 MUL r2×r3 unsigned, low 16 bits; 101 AND r2&r3; 110 CLR, result 0; 111 SLL r2<<entrada[3:0].
- Immediate: 7-bit two's complement, sign-extended from `entrada[6]` to WIDTH.
- Add/sub wrap modulo 2^16. `estouro`: ADD/ADDI/SUB/SUBI signed overflow; MUL = 1 iff product bits [31:16] ≠ 0; 0 for AND, CLR, SLL.
- States:
  - OCIOSO: if `inicio`=1 and `flag_ram`=0, latch opcode, r2, r3 and entrada. Go to MULT if opcode=100, else CALC. Any other input combination: stay.
  - CALC: compute from the latched values; load `saida` and `estouro`; set `fimop`; go to PRONTO.
  - MULT: one shift-add step per cycle for 16 cycles, counter 0..15. After the step with counter=15, load `saida`/`estouro`, set `fimop`, go to PRONTO.
  - PRONTO: hold `fimop`=1, `saida` and `estouro` stable. When `flag_ram`=1: clear `fimop`, go to LIBERA.
  - LIBERA: wait for `flag_ram`=0 and `inicio`=0, then go to OCIOSO.
- Operands are latched at acceptance; changes on `r2`/`r3`/`entrada`/`opcode` after that have no effect on the current operation.
- `inicio` while `ocupado`=1 is ignored. No queuing.
- `saida` keeps the last result through LIBERA and OCIOSO until the next result loads.

## Timing
- Reset (async assert, any state including mid-MULT): `saida`=0, `fimop`=0, `estouro`=0, `ocupado`=0, state OCIOSO, counter 0, partial product discarded. Release is synchronous to `clk`.
- Acceptance at edge k: single-cycle ops have `fimop`=1 and valid `saida` after edge k+1. MUL has them after edge k+17.
- `fimop` falls on the edge after `flag_ram` is sampled high, which is one cycle minimum.
- Minimum full transaction with immediate acknowledge: 4 cycles for single-cycle ops, 20 cycles for MUL.
- Stale acknowledge: `flag_ram`=1 in OCIOSO blocks acceptance even with `inicio`=1.
- Simultaneous `inicio` drop and `flag_ram` rise in PRONTO: completes normally. LIBERA then exits as soon as `flag_ram` falls.

## Structure
- Shared package `cpu_pkg`: opcode constants (OP_ADD … OP_SLL) and the state enum (OCIOSO, CALC, MULT, PRONTO, LIBERA). The register-file controller imports the same opcode constants.
- One sub-module, `multiplicador_serial`:
  - inputs: start, a, b
  - outputs: done, 32-bit product
  - contains the counter and the shift-add datapath
- The top level holds the FSM, the operand latches and the single-cycle ALU.

## Test plan
- ADDI r2=0x0005, entrada=7'h7E (−2), immediate ack → `saida`=0x0003, `estouro`=0, `fimop` high exactly 1 cycle after acceptance.
- ADD 0x7FFF+0x0001 → `saida`=0x8000, `estouro`=1. SUB 0x0000−0x0001 → `saida`=0xFFFF, `estouro`=0.
- MUL 0x0123×0x0010 → `saida`=0x1230, `estouro`=0, `fimop` after 17 cycles. MUL 0x0100×0x0100 → `saida`=0x0000, `estouro`=1.
- Delay `flag_ram` by 10 cycles; change r2/r3 after acceptance → `fimop` and `saida` held constant, result uses the latched operands. Pulse `inicio` while busy → ignored.
- `rst_n` low at MULT step 8 → all outputs 0 immediately. After release, SLL r2=0x0001, entrada[3:0]=15 → `saida`=0x8000.
- `flag_ram` held high in OCIOSO with `inicio`=1 → no acceptance, `ocupado`=0. Drop `flag_ram` → accepted next edge.
